// File: rtl/dmem_arbiter_if.sv
// Requester-side port bundle of the data-SRAM arbiter: one instance per requester.
// Suffixes are as seen from the arbiter (_i into it, _o out of it).
interface dmem_arbiter_if #(
  parameter int ADDR_W = 16
);
  logic              req_i;
  logic              we_i;
  logic [ADDR_W-1:0] addr_i;
  logic [31:0]       wdata_i;
  logic [3:0]        be_i;
  logic              gnt_o;
  logic              rvalid_o;
  logic [31:0]       rdata_o;

  modport master (
    output req_i, we_i, addr_i, wdata_i, be_i,
    input  gnt_o, rvalid_o, rdata_o
  );

  modport slave (
    input  req_i, we_i, addr_i, wdata_i, be_i,
    output gnt_o, rvalid_o, rdata_o
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter between the core LSU (m0) and the loader/debug port (m1)
// in front of a single-port SRAM with fixed read latency; one access in flight.
module dmem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int RD_LAT = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  dmem_arbiter_if.slave     m0,
  dmem_arbiter_if.slave     m1,
  output logic              mem_cs_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  output logic [3:0]        mem_be_o,
  input  logic [31:0]       mem_rdata_i
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RWAIT = 2'd1,
    RESP  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        last_q, last_d;
  logic        owner_q, owner_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        any_req_s;
  logic        win_s;
  logic        sel_we_s;

  // Next-state, grant, SRAM drive and read-return decode.
  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    owner_d      = owner_q;
    cnt_d        = cnt_q;
    m0.gnt_o     = 1'b0;
    m1.gnt_o     = 1'b0;
    m0.rvalid_o  = 1'b0;
    m1.rvalid_o  = 1'b0;
    m0.rdata_o   = 32'd0;
    m1.rdata_o   = 32'd0;
    mem_cs_o     = 1'b0;
    mem_we_o     = 1'b0;
    mem_addr_o   = {ADDR_W{1'b0}};
    mem_wdata_o  = 32'd0;
    mem_be_o     = 4'd0;
    any_req_s    = m0.req_i | m1.req_i;
    sel_we_s     = 1'b0;

    // On a tie the side that did not win last time goes; otherwise the lone requester.
    if (m0.req_i && m1.req_i) begin
      win_s = ~last_q;
    end else begin
      win_s = m1.req_i;
    end

    case (state_q)
      IDLE: begin
        if (any_req_s) begin
          m0.gnt_o    = ~win_s;
          m1.gnt_o    = win_s;
          sel_we_s    = win_s ? m1.we_i : m0.we_i;
          mem_cs_o    = 1'b1;
          mem_we_o    = sel_we_s;
          mem_addr_o  = win_s ? m1.addr_i  : m0.addr_i;
          mem_wdata_o = win_s ? m1.wdata_i : m0.wdata_i;
          mem_be_o    = win_s ? m1.be_i    : m0.be_i;
          last_d      = win_s;
          if (!sel_we_s) begin
            owner_d = win_s;
            cnt_d   = 3'(RD_LAT - 1);
            state_d = (RD_LAT == 1) ? RESP : RWAIT;
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RWAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          state_d = RESP;
        end else begin
          state_d = RWAIT;
        end
      end
      RESP: begin
        if (owner_q) begin
          m1.rvalid_o = 1'b1;
          m1.rdata_o  = mem_rdata_i;
        end else begin
          m0.rvalid_o = 1'b1;
          m0.rdata_o  = mem_rdata_i;
        end
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register; reset makes m0 the winner of the first tie.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      owner_q <= 1'b0;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench: three arbiter instances with read latencies 2, 3 and 1,
// each with a small SRAM model; expected values are hand-computed constants.
module tb_dmem_arbiter;

  localparam int AW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_na, rst_nb, rst_nc;
  int   n_chk  = 0;
  int   n_fail = 0;

  dmem_arbiter_if #(.ADDR_W(AW)) a0 (), a1 (), b0 (), b1 (), c0 (), c1 ();

  logic          a_cs, a_we, b_cs, b_we, c_cs, c_we;
  logic [AW-1:0] a_addr, b_addr, c_addr;
  logic [31:0]   a_wdata, b_wdata, c_wdata;
  logic [3:0]    a_be, b_be, c_be;
  logic [31:0]   a_rdata, b_rdata, c_rdata;

  dmem_arbiter #(.ADDR_W(AW), .RD_LAT(2)) u_a (
    .clk_i(clk), .rst_ni(rst_na), .m0(a0), .m1(a1),
    .mem_cs_o(a_cs), .mem_we_o(a_we), .mem_addr_o(a_addr),
    .mem_wdata_o(a_wdata), .mem_be_o(a_be), .mem_rdata_i(a_rdata)
  );

  dmem_arbiter #(.ADDR_W(AW), .RD_LAT(3)) u_b (
    .clk_i(clk), .rst_ni(rst_nb), .m0(b0), .m1(b1),
    .mem_cs_o(b_cs), .mem_we_o(b_we), .mem_addr_o(b_addr),
    .mem_wdata_o(b_wdata), .mem_be_o(b_be), .mem_rdata_i(b_rdata)
  );

  dmem_arbiter #(.ADDR_W(AW), .RD_LAT(1)) u_c (
    .clk_i(clk), .rst_ni(rst_nc), .m0(c0), .m1(c1),
    .mem_cs_o(c_cs), .mem_we_o(c_we), .mem_addr_o(c_addr),
    .mem_wdata_o(c_wdata), .mem_be_o(c_be), .mem_rdata_i(c_rdata)
  );

  // SRAM model for the RD_LAT=2 instance: byte-masked writes, two-stage read pipe.
  logic [31:0] mem_a [0:255];
  logic [31:0] pa1 = 32'd0;
  logic [31:0] pa2 = 32'd0;

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old_w;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
    end
    return r;
  endfunction

  always @(posedge clk) begin
    if (a_cs && a_we) mem_a[a_addr[9:2]] <= merge(mem_a[a_addr[9:2]], a_wdata, a_be);
    if (a_cs && !a_we) pa1 <= mem_a[a_addr[9:2]];
    pa2 <= pa1;
  end
  assign a_rdata = pa2;

  // The RD_LAT=3 instance only needs a visible data pattern; RD_LAT=1 has a one-stage pipe.
  assign b_rdata = 32'h0BAD_F00D;
  logic [31:0] pc1 = 32'd0;
  always @(posedge clk) begin
    if (c_cs && !c_we) pc1 <= (c_addr == 16'h0020) ? 32'hCAFE_F00D : 32'h0000_0000;
  end
  assign c_rdata = pc1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic req, input logic we, input logic [AW-1:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be, input int which);
    case (which)
      0: begin a0.req_i = req; a0.we_i = we; a0.addr_i = addr; a0.wdata_i = wdata; a0.be_i = be; end
      1: begin a1.req_i = req; a1.we_i = we; a1.addr_i = addr; a1.wdata_i = wdata; a1.be_i = be; end
      2: begin b0.req_i = req; b0.we_i = we; b0.addr_i = addr; b0.wdata_i = wdata; b0.be_i = be; end
      3: begin b1.req_i = req; b1.we_i = we; b1.addr_i = addr; b1.wdata_i = wdata; b1.be_i = be; end
      4: begin c0.req_i = req; c0.we_i = we; c0.addr_i = addr; c0.wdata_i = wdata; c0.be_i = be; end
      default: begin c1.req_i = req; c1.we_i = we; c1.addr_i = addr; c1.wdata_i = wdata; c1.be_i = be; end
    endcase
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) mem_a[i] = 32'd0;
    mem_a[4] = 32'hDEAD_BEEF;
    mem_a[2] = 32'hAABB_CCDD;
    rst_na = 1'b0; rst_nb = 1'b0; rst_nc = 1'b0;
    for (int w = 0; w < 6; w++) drive(1'b0, 1'b0, 16'h0000, 32'd0, 4'h0, w);

    // Reset state
    next_cycle();
    @(negedge clk);
    chk("rst_gnt0", {31'd0, a0.gnt_o}, 32'd0);
    chk("rst_cs", {31'd0, a_cs}, 32'd0);
    chk("rst_rvalid0", {31'd0, a0.rvalid_o}, 32'd0);
    next_cycle();
    rst_na = 1'b1; rst_nb = 1'b1; rst_nc = 1'b1;

    // m0 read 0x0010, latency 2
    drive(1'b1, 1'b0, 16'h0010, 32'd0, 4'hF, 0);
    @(negedge clk);
    chk("rd_gnt0", {31'd0, a0.gnt_o}, 32'd1);
    chk("rd_gnt1", {31'd0, a1.gnt_o}, 32'd0);
    chk("rd_cs", {31'd0, a_cs}, 32'd1);
    chk("rd_we", {31'd0, a_we}, 32'd0);
    chk("rd_addr", {16'd0, a_addr}, 32'h0000_0010);
    next_cycle();
    drive(1'b0, 1'b0, 16'h0000, 32'd0, 4'h0, 0);
    @(negedge clk);
    chk("rwait_cs", {31'd0, a_cs}, 32'd0);
    chk("rwait_rvalid0", {31'd0, a0.rvalid_o}, 32'd0);
    next_cycle();
    @(negedge clk);
    chk("resp_rvalid0", {31'd0, a0.rvalid_o}, 32'd1);
    chk("resp_rdata0", a0.rdata_o, 32'hDEAD_BEEF);
    chk("resp_rvalid1", {31'd0, a1.rvalid_o}, 32'd0);
    chk("resp_rdata1", a1.rdata_o, 32'd0);
    next_cycle();
    @(negedge clk);
    chk("post_rvalid0", {31'd0, a0.rvalid_o}, 32'd0);
    chk("post_rdata0", a0.rdata_o, 32'd0);
    next_cycle();

    // Fresh reset, then both sides write continuously: strict alternation from m0
    rst_na = 1'b0;
    #2;
    rst_na = 1'b1;
    drive(1'b1, 1'b1, 16'h0000, 32'h1111_1111, 4'hF, 0);
    drive(1'b1, 1'b1, 16'h0004, 32'h2222_2222, 4'hF, 1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("alt_gnt0_%0d", k), {31'd0, a0.gnt_o}, (k % 2 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("alt_gnt1_%0d", k), {31'd0, a1.gnt_o}, (k % 2 == 0) ? 32'd0 : 32'd1);
      chk($sformatf("alt_addr_%0d", k), {16'd0, a_addr}, (k % 2 == 0) ? 32'h0 : 32'h4);
      next_cycle();
    end
    drive(1'b0, 1'b0, 16'h0000, 32'd0, 4'h0, 0);
    drive(1'b0, 1'b0, 16'h0000, 32'd0, 4'h0, 1);

    // m1 partial write then read back the same word
    drive(1'b1, 1'b1, 16'h0008, 32'h1234_5678, 4'b0011, 1);
    @(negedge clk);
    chk("pw_gnt1", {31'd0, a1.gnt_o}, 32'd1);
    chk("pw_be", {28'd0, a_be}, 32'h3);
    chk("pw_wdata", a_wdata, 32'h1234_5678);
    next_cycle();
    drive(1'b1, 1'b0, 16'h0008, 32'd0, 4'b0011, 1);
    @(negedge clk);
    chk("pr_gnt1", {31'd0, a1.gnt_o}, 32'd1);
    chk("pr_we", {31'd0, a_we}, 32'd0);
    chk("pr_be", {28'd0, a_be}, 32'h3);
    next_cycle();
    drive(1'b0, 1'b0, 16'h0000, 32'd0, 4'h0, 1);
    next_cycle();
    @(negedge clk);
    chk("pr_rvalid1", {31'd0, a1.rvalid_o}, 32'd1);
    chk("pr_rdata1", a1.rdata_o, 32'hAABB_5678);
    chk("pr_rvalid0", {31'd0, a0.rvalid_o}, 32'd0);
    next_cycle();

    // m0 read in flight; m1 raised one cycle later waits until IDLE
    drive(1'b1, 1'b0, 16'h0000, 32'd0, 4'hF, 0);
    @(negedge clk);
    chk("ov_gnt0", {31'd0, a0.gnt_o}, 32'd1);
    next_cycle();
    drive(1'b0, 1'b0, 16'h0000, 32'd0, 4'h0, 0);
    drive(1'b1, 1'b1, 16'h000C, 32'h3333_3333, 4'hF, 1);
    @(negedge clk);
    chk("ov_gnt1_c6", {31'd0, a1.gnt_o}, 32'd0);
    next_cycle();
    @(negedge clk);
    chk("ov_gnt1_c7", {31'd0, a1.gnt_o}, 32'd0);
    chk("ov_rvalid0", {31'd0, a0.rvalid_o}, 32'd1);
    chk("ov_rdata0", a0.rdata_o, 32'h1111_1111);
    next_cycle();
    @(negedge clk);
    chk("ov_gnt1_c8", {31'd0, a1.gnt_o}, 32'd1);
    chk("ov_addr_c8", {16'd0, a_addr}, 32'h0000_000C);
    next_cycle();
    drive(1'b0, 1'b0, 16'h0000, 32'd0, 4'h0, 1);

    // RD_LAT=3: reset during RWAIT kills the pending response and restores m0 priority
    drive(1'b1, 1'b0, 16'h0040, 32'd0, 4'hF, 2);
    @(negedge clk);
    chk("ar_gnt0", {31'd0, b0.gnt_o}, 32'd1);
    next_cycle();
    drive(1'b0, 1'b0, 16'h0000, 32'd0, 4'h0, 2);
    @(negedge clk);
    chk("ar_cs", {31'd0, b_cs}, 32'd0);
    #1;
    rst_nb = 1'b0;
    next_cycle();
    rst_nb = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("ar_rvalid0_%0d", k), {31'd0, b0.rvalid_o}, 32'd0);
      chk($sformatf("ar_rvalid1_%0d", k), {31'd0, b1.rvalid_o}, 32'd0);
      next_cycle();
    end
    drive(1'b1, 1'b1, 16'h0050, 32'h5555_5555, 4'hF, 2);
    drive(1'b1, 1'b1, 16'h0054, 32'h6666_6666, 4'hF, 3);
    @(negedge clk);
    chk("ar_tie_gnt0", {31'd0, b0.gnt_o}, 32'd1);
    chk("ar_tie_gnt1", {31'd0, b1.gnt_o}, 32'd0);
    next_cycle();
    drive(1'b0, 1'b0, 16'h0000, 32'd0, 4'h0, 2);
    drive(1'b0, 1'b0, 16'h0000, 32'd0, 4'h0, 3);

    // RD_LAT=1: continuous m0 reads give a 2-cycle grant/response period
    drive(1'b1, 1'b0, 16'h0020, 32'd0, 4'hF, 4);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk($sformatf("l1_gnt0_%0d", k), {31'd0, c0.gnt_o}, (k % 2 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("l1_rvalid0_%0d", k), {31'd0, c0.rvalid_o}, (k % 2 == 0) ? 32'd0 : 32'd1);
      chk($sformatf("l1_rdata0_%0d", k), c0.rdata_o, (k % 2 == 0) ? 32'd0 : 32'hCAFE_F00D);
      next_cycle();
    end
    drive(1'b0, 1'b0, 16'h0000, 32'd0, 4'h0, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

- Two-requester arbiter for the single-port data SRAM behind the LSU.
- Requester 0 is the core LSU; requester 1 is the program loader/debug port.
- Sequences each access: combinational grant, fixed-latency read return.
- Arbitrates round-robin so neither side starves; the core stalls on `m0_req_i && !m0_gnt_o`.

## Interface

Parameters
- `ADDR_W`, 16: byte-address width on all ports.
- `RD_LAT`, 2: SRAM read latency in cycles, legal range 1..7.

Ports (`x` = 0 or 1)
- `clk_i`, input, 1: system clock; all state on the rising edge.
- `rst_ni`, input, 1: reset, asynchronous and active-low.
- `mx_req_i`, input, 1: access request; held until granted.
- `mx_we_i`, input, 1: 1 = write, 0 = read.
- `mx_addr_i`, input, ADDR_W: byte address.
- `mx_wdata_i`, input, 32: write data.
- `mx_be_i`, input, 4: byte enables for writes.
- `mx_gnt_o`, output, 1: request accepted this cycle.
- `mx_rvalid_o`, output, 1: one-cycle pulse, read data valid.
- `mx_rdata_o`, output, 32: read data; valid only while `mx_rvalid_o` = 1, otherwise 0.
- `mem_cs_o`, output, 1: SRAM chip select.
- `mem_we_o`, output, 1: SRAM write enable.
- `mem_addr_o`, output, ADDR_W: SRAM address.
- `mem_wdata_o`, output, 32: SRAM write data.
- `mem_be_o`, output, 4: SRAM byte enables.
- `mem_rdata_i`, input, 32: SRAM read data, valid `RD_LAT` cycles after a read cs.

## Operation

States: `IDLE`, `RWAIT`, `RESP`. Registers: `state_q`, `last_q` (last granted requester), `owner_q`, `cnt_q` (3 bits).

Reset values:
- `state_q` = `IDLE`, `last_q` = 1 (so m0 wins the first tie), `cnt_q` = 0.
- All outputs 0.

`IDLE`:
- Select winner `w`:
  - only one requester active: that one;
  - both active: the requester ≠ `last_q`.
- Assert `mw_gnt_o` combinationally in the same cycle.
- Drive `mem_cs_o` = 1 and `mem_we_o/addr/wdata/be` from `w`.
- Update `last_q` <= `w`.
- If a write: stay in `IDLE`; the write is complete.
- If a read: `owner_q` <= `w`, `cnt_q` <= `RD_LAT`-1. Go to `RESP` if `RD_LAT` = 1, else `RWAIT`.
- No requests: `mem_cs_o` = 0 and all `mem_*` outputs = 0.

`RWAIT`:
- No grants; `mem_cs_o` = 0.
- Decrement `cnt_q`; at `cnt_q` = 1 go to `RESP`.

`RESP`:
- `m[owner_q]_rvalid_o` = 1 and `m[owner_q]_rdata_o` = `mem_rdata_i`.
- No grants in this cycle.
- Next state `IDLE`.

Rules:
- At most one transaction is outstanding.
- A requester that drops `req` before being granted is simply skipped. No error is raised.
- `be` is ignored for reads; `mem_be_o` is driven anyway.

## Timing

- Grant latency: 0 cycles from `req` while in `IDLE`.
- Write: occupies exactly 1 cycle. Back-to-back writes sustain 1 per cycle.
- Read granted at cycle t:
  - `rvalid` at cycle t+`RD_LAT`;
  - next grant no earlier than t+`RD_LAT`+1.
- Read throughput: 1 per `RD_LAT`+1 cycles.
- Fairness: with both requesters continuously active, grants strictly alternate 0,1,0,1…
- Reset asserted mid-read:
  - state returns to `IDLE` immediately (async);
  - the pending `rvalid` is never issued;
  - `last_q` = 1.
- Simultaneous new request and `RESP`: the request waits and is granted in the following `IDLE` cycle.
- `mem_*` outputs are combinational from the selected requester inputs. The SRAM samples them on the same `clk_i` edge as the grant.

## Test plan

- Reset, then m0 read 0x0010 only, `RD_LAT`=2, SRAM word 0xDEADBEEF:
  - `m0_gnt_o` at cycle 0;
  - `m0_rvalid_o` = 1 with 0xDEADBEEF at cycle 2;
  - `m1_rvalid_o` stays 0.
- Both requesters write continuously, m0 to 0x0000, m1 to 0x0004, starting right after reset: grants go m0,m1,m0,m1 on consecutive cycles and `mem_addr_o` alternates 0x0000/0x0004.
- m1 write 0x0008, `be`=4'b0011, `wdata`=0x12345678, then m1 reads 0x0008: readback lower half 0x5678 with the upper bytes unchanged.
- m0 read grant at cycle 5, m1 request raised at cycle 6:
  - `m1_gnt_o` stays 0 through cycle 7 (`RESP`);
  - granted at cycle 8.
- `rst_ni` pulled low at cycle 1 of a `RWAIT` with `RD_LAT`=3: no `rvalid` afterwards; after release, the first tie goes to m0.
- `RD_LAT`=1, m0 reads 0x0020 every opportunity: `rvalid` on every other cycle, 2-cycle period.
